mem_stage: RTL and testbench

//  MEM stage of the 5-stage RV32I pipeline, directly downstream of EX. Owns the EX/MEM pipeline register.

---
 rtl/mem_stage_pkg.sv | 49 ++++
 rtl/mem_stage_load_align.sv | 33 +++
 rtl/mem_stage.sv | 118 +++++++++++
 tb/tb_mem_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - rv32i_types: pipeline register structs and MEM stage state for mem_stage
package rv32i_types;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Bit positions inside load_mask; no bit set means a full-word load.
    localparam int LM_LB  = 0;
    localparam int LM_LH  = 1;
    localparam int LM_LBU = 2;
    localparam int LM_LHU = 3;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        regf_we;
        logic [3:0]  load_mask;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_rmask;
        logic [3:0]  dmem_wmask;
        logic [31:0] dmem_wdata;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        regf_we;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_rmask;
        logic [3:0]  dmem_wmask;
        logic [31:0] dmem_wdata;
        logic [31:0] dmem_rdata;
    } mem_wb_t;

    typedef struct packed {
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        regf_we;
    } fwd_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - load_align: lane select and sign/zero extension of load data
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [3:0]  rmask,
    input  logic [3:0]  load_mask,
    output logic [31:0] rd_v
);

    logic [1:0]  off;
    logic [31:0] lane;

    always_comb begin
        off = 2'd0;
        // Lowest strobed byte lane gives the byte offset of the access.
        for (int i = 3; i >= 0; i--) begin
            if (rmask[i]) off = 2'(i);
        end
        lane = rdata >> {off, 3'b000};
        if (load_mask[LM_LB])
            rd_v = {{24{lane[7]}}, lane[7:0]};
        else if (load_mask[LM_LH])
            rd_v = {{16{lane[15]}}, lane[15:0]};
        else if (load_mask[LM_LBU])
            rd_v = {24'd0, lane[7:0]};
        else if (load_mask[LM_LHU])
            rd_v = {16'd0, lane[15:0]};
        else
            rd_v = lane;
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I MEM stage: EX/MEM register, dmem handshake, load alignment
// Optional request timeout enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage
    import rv32i_types::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ex_mem_t     ex_mem_reg_next,
    input  logic [31:0] ex_dmem_addr,
    input  logic [3:0]  ex_dmem_rmask,
    input  logic [3:0]  ex_dmem_wmask,
    input  logic [31:0] ex_dmem_wdata,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output mem_wb_t     mem_wb_reg_next,
    output fwd_t        mem_fwd,
`ifdef MEM_STAGE_TIMEOUT_EN
    output logic        mem_stall,
    output logic        timeout_err
`else
    output logic        mem_stall
`endif
);

    ex_mem_t     ex_mem_q;
    mem_state_t  state, state_n;
    logic        timeout;
    logic        issue;
    logic        is_load, is_store;
    logic        retire_v;
    logic [31:0] load_rd_v;
    logic [31:0] rd_v_fin;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // wait_cnt holds completed WAIT cycles, so the last allowed cycle sees TIMEOUT_CYCLES-1.
    assign timeout     = (state == WAIT) & ~dmem_resp & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (mem_stall)
            wait_cnt <= wait_cnt + CW'(1);
        else
            wait_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    assign mem_stall = (state == WAIT) & ~dmem_resp & ~timeout;
    assign issue     = rst_n & ~mem_stall & ex_mem_reg_next.valid;

    assign dmem_addr  = issue ? ex_dmem_addr  : 32'd0;
    assign dmem_rmask = issue ? ex_dmem_rmask : 4'd0;
    assign dmem_wmask = issue ? ex_dmem_wmask : 4'd0;
    assign dmem_wdata = issue ? ex_dmem_wdata : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_q <= '0;
            state    <= IDLE;
        end else begin
            state <= state_n;
            if (!mem_stall) ex_mem_q <= ex_mem_reg_next;
        end
    end

    always_comb begin
        state_n = state;
        if (!mem_stall)
            state_n = (ex_mem_reg_next.valid &&
                       (|(ex_mem_reg_next.dmem_rmask | ex_mem_reg_next.dmem_wmask))) ? WAIT : IDLE;
    end

    load_align u_load_align (
        .rdata     (dmem_rdata),
        .rmask     (ex_mem_q.dmem_rmask),
        .load_mask (ex_mem_q.load_mask),
        .rd_v      (load_rd_v)
    );

    assign is_load  = |ex_mem_q.dmem_rmask;
    assign is_store = |ex_mem_q.dmem_wmask;
    assign rd_v_fin = is_load ? load_rd_v : ex_mem_q.rd_v;
    // An abandoned request leaves the stage as a bubble.
    assign retire_v = ex_mem_q.valid & ~mem_stall & ~timeout;

    always_comb begin
        mem_wb_reg_next            = '0;
        mem_wb_reg_next.valid      = retire_v;
        mem_wb_reg_next.pc         = ex_mem_q.pc;
        mem_wb_reg_next.inst       = ex_mem_q.inst;
        mem_wb_reg_next.rd_s       = is_store ? 5'd0 : ex_mem_q.rd_s;
        mem_wb_reg_next.rd_v       = rd_v_fin;
        mem_wb_reg_next.regf_we    = ex_mem_q.regf_we & ~is_store;
        mem_wb_reg_next.dmem_addr  = ex_mem_q.dmem_addr;
        mem_wb_reg_next.dmem_rmask = ex_mem_q.dmem_rmask;
        mem_wb_reg_next.dmem_wmask = ex_mem_q.dmem_wmask;
        mem_wb_reg_next.dmem_wdata = ex_mem_q.dmem_wdata;
        mem_wb_reg_next.dmem_rdata = dmem_rdata;

        mem_fwd         = '0;
        mem_fwd.rd_s    = is_store ? 5'd0 : ex_mem_q.rd_s;
        mem_fwd.rd_v    = rd_v_fin;
        mem_fwd.regf_we = retire_v & ex_mem_q.regf_we & ~is_store;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a transaction model
`timescale 1ns/1ps
module tb_mem_stage;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ex_mem_t     ex_next;
    logic [31:0] ex_addr, ex_wdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  ex_rmask, ex_wmask, dmem_rmask, dmem_wmask;
    logic        dmem_resp;
    mem_wb_t     wb;
    fwd_t        fwd;
    logic        mem_stall;
`ifdef MEM_STAGE_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 clk = ~clk;

`ifdef MEM_STAGE_TIMEOUT_EN
    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
`else
    mem_stage dut (
`endif
        .clk(clk), .rst_n(rst_n), .ex_mem_reg_next(ex_next),
        .ex_dmem_addr(ex_addr), .ex_dmem_rmask(ex_rmask), .ex_dmem_wmask(ex_wmask),
        .ex_dmem_wdata(ex_wdata), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .mem_wb_reg_next(wb), .mem_fwd(fwd),
`ifdef MEM_STAGE_TIMEOUT_EN
        .mem_stall(mem_stall), .timeout_err(timeout_err)
`else
        .mem_stall(mem_stall)
`endif
    );

    // kind: 0 alu, 1 lb, 2 lh, 3 lbu, 4 lhu, 5 lw, 6 sw
    typedef struct {
        ex_mem_t     e;
        int          kind;
        int          off;
        int          d;
        logic [31:0] rdata;
    } op_t;

    op_t  q[$];
    op_t  cur, occ, bubble;
    logic occ_v;
    int   left;
    bit   force_stray;
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk(int kind, int off, int d, logic [31:0] rdata,
                               logic [4:0] rd, logic [31:0] rdv);
        op_t         o;
        logic [31:0] tmp;
        o.e = '0;
        o.kind = kind; o.off = off; o.d = d; o.rdata = rdata;
        o.e.valid = 1'b1;
        o.e.pc = $urandom; o.e.inst = $urandom;
        o.e.rd_s = rd; o.e.rd_v = rdv; o.e.regf_we = 1'b1;
        tmp = $urandom;
        o.e.dmem_addr = tmp & 32'hFFFF_FFFC;
        case (kind)
            0: o.e.regf_we = 1'($urandom % 2);
            1: begin o.e.dmem_rmask = 4'(1 << off); o.e.load_mask = 4'b0001; end
            2: begin o.e.dmem_rmask = 4'(3 << off); o.e.load_mask = 4'b0010; end
            3: begin o.e.dmem_rmask = 4'(1 << off); o.e.load_mask = 4'b0100; end
            4: begin o.e.dmem_rmask = 4'(3 << off); o.e.load_mask = 4'b1000; end
            5: o.e.dmem_rmask = 4'hF;
            default: begin
                o.e.dmem_wmask = 4'($urandom_range(1, 15));
                o.e.dmem_wdata = $urandom;
                o.e.rd_s = 5'd0;
                o.e.regf_we = 1'($urandom % 2);
            end
        endcase
        if (kind == 0) o.d = 0;
        return o;
    endfunction

    function automatic logic [31:0] ref_load(int kind, int off, logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (8 * off)) & 32'hFFFF;
        case (kind)
            1: return (b >= 128) ? b - 32'd256 : b;
            2: return (h >= 32768) ? h - 32'd65536 : h;
            3: return b;
            4: return h;
            default: return rdata;
        endcase
    endfunction

    task automatic drive_ex(input op_t o);
        ex_next  = o.e;
        ex_addr  = o.e.dmem_addr;
        ex_rmask = o.e.dmem_rmask;
        ex_wmask = o.e.dmem_wmask;
        ex_wdata = o.e.dmem_wdata;
    endtask

    task automatic check_reset_outputs();
        chk("rst_stall", mem_stall, 0);
        chk("rst_rmask", dmem_rmask, 0);
        chk("rst_wmask", dmem_wmask, 0);
        chk("rst_wb_valid", wb.valid, 0);
        chk("rst_fwd_we", fwd.regf_we, 0);
`ifdef MEM_STAGE_TIMEOUT_EN
        chk("rst_timeout", timeout_err, 0);
`endif
    endtask

    task automatic cycle(input bit allow_bubble);
        bit          stall_e, ret, occ_mem, st;
        logic [31:0] rdv;
        @(negedge clk);
        occ_mem = occ_v && occ.kind != 0;
        stall_e = occ_mem && left > 0;
        if (!stall_e) begin
            if (q.size() > 0 && !(allow_bubble && $urandom % 5 == 0)) cur = q.pop_front();
            else cur = bubble;
        end
        drive_ex(cur);
        dmem_resp  = occ_mem ? (left == 0) : (force_stray || $urandom % 4 == 0);
        dmem_rdata = (occ_mem && left == 0) ? occ.rdata : $urandom;
        #1;
        chk("stall", mem_stall, stall_e);
        chk("rmask", dmem_rmask, (!stall_e && cur.e.valid) ? cur.e.dmem_rmask : 4'd0);
        chk("wmask", dmem_wmask, (!stall_e && cur.e.valid) ? cur.e.dmem_wmask : 4'd0);
        chk("addr", dmem_addr, (!stall_e && cur.e.valid) ? cur.e.dmem_addr : 32'd0);
        chk("wdata", dmem_wdata, (!stall_e && cur.e.valid) ? cur.e.dmem_wdata : 32'd0);
        ret = occ_v && !stall_e;
        st  = occ.kind == 6;
        chk("wb_valid", wb.valid, ret);
        chk("fwd_we", fwd.regf_we, ret && !st && occ.e.regf_we);
        if (ret) begin
            rdv = (occ.kind >= 1 && occ.kind <= 5) ? ref_load(occ.kind, occ.off, occ.rdata) : occ.e.rd_v;
            chk("wb_rd_v", wb.rd_v, rdv);
            chk("fwd_rd_v", fwd.rd_v, rdv);
            chk("wb_rd_s", wb.rd_s, st ? 5'd0 : occ.e.rd_s);
            chk("wb_we", wb.regf_we, !st && occ.e.regf_we);
            if (occ.kind >= 1 && occ.kind <= 5) chk("wb_rdata", wb.dmem_rdata, occ.rdata);
        end
        if (!stall_e) begin
            occ   = cur;
            occ_v = cur.e.valid;
            left  = cur.d;
        end else begin
            left--;
        end
    endtask

    initial begin
        int guard;
        bubble.e = '0; bubble.kind = 0; bubble.off = 0; bubble.d = 0; bubble.rdata = '0;
        cur = bubble; occ = bubble; occ_v = 1'b0; left = 0; force_stray = 1'b0;
        dmem_resp = 1'b0; dmem_rdata = '0;

        // Reset with a live load presented by EX
        rst_n = 1'b0;
        drive_ex(mk(5, 0, 0, 0, 5'd3, 0));
        @(negedge clk); #1;
        check_reset_outputs();
        drive_ex(bubble);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: addi, lb slow, lhu, sw then lw back-to-back
        q.push_back(mk(0, 0, 0, 0, 5'd5, 32'h10));
        q.push_back(mk(1, 2, 3, 32'h0080_0000, 5'd6, 0));
        q.push_back(mk(4, 2, 1, 32'hBEEF_0000, 5'd7, 0));
        q.push_back(mk(6, 0, 1, $urandom, 5'd0, 0));
        q.push_back(mk(5, 0, 1, 32'hCAFE_F00D, 5'd8, 0));
        for (int i = 0; i < 20; i++) cycle(0);

        // Reset while a request is outstanding, then a stray response
        q.push_back(mk(5, 0, 3, $urandom, 5'd9, 0));
        guard = 0;
        do begin cycle(0); guard++; end
        while (!(occ_v && occ.kind != 0 && left > 0) && guard < 10);
        chk("reach_wait", guard < 10, 1);
        @(negedge clk);
        rst_n = 1'b0;
        drive_ex(mk(2, 2, 0, 0, 5'd4, 0));
        #1;
        check_reset_outputs();
        drive_ex(bubble);
        @(negedge clk);
        rst_n = 1'b1;
        occ = bubble; occ_v = 1'b0; left = 0; cur = bubble;
        force_stray = 1'b1;
        cycle(0);
        cycle(0);
        force_stray = 1'b0;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            int k, off;
            k = $urandom_range(0, 6);
            off = (k == 2 || k == 4) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
            q.push_back(mk(k, off, $urandom_range(0, 3), $urandom, 5'($urandom), $urandom));
        end
        guard = 0;
        while (q.size() > 0 && guard < 5000) begin cycle(1); guard++; end
        chk("random_drain", q.size(), 0);
        for (int i = 0; i < 6; i++) cycle(0);

`ifdef MEM_STAGE_TIMEOUT_EN
        // Never-answered load is abandoned in its fourth WAIT cycle
        begin
            op_t alu;
            q.push_back(mk(5, 0, 99, $urandom, 5'd10, 0));
            cycle(0);
            alu = mk(0, 0, 0, 0, 5'd11, 32'h1234);
            for (int w = 1; w <= 4; w++) begin
                @(negedge clk);
                drive_ex(alu);
                dmem_resp = 1'b0;
                dmem_rdata = $urandom;
                #1;
                chk("to_stall", mem_stall, w < 4);
                chk("to_err", timeout_err, w == 4);
                chk("to_wb_valid", wb.valid, 0);
                chk("to_fwd_we", fwd.regf_we, 0);
            end
            occ = alu; occ_v = 1'b1; left = 0; cur = alu;
            cycle(0);
            @(negedge clk); #1;
            chk("to_err_once", timeout_err, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
